// File: rtl/head_pkg.sv
// Shared definitions for the head detect / restore path: word and position-code
// widths, the restore FSM state type and the position clamp helper.
package head_pkg;

    localparam int HEAD_W     = 32;
    localparam int HEAD_POS_W = 6;
    localparam int HEAD_REM_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } head_restore_state_t;

    // Codes past the word width collapse to a full-width shift, which yields zero.
    function automatic logic [HEAD_REM_W-1:0] clamp_pos(input logic [HEAD_POS_W-1:0] pos);
        if (pos > HEAD_POS_W'(HEAD_W))
            return HEAD_REM_W'(HEAD_W);
        else
            return {1'b0, pos};
    endfunction

endpackage

// File: rtl/head_restore_step.sv
// One iteration of the restore shift: picks min(STEP, rem), shifts the word
// right by that amount through a log-stage shifter and decrements rem.
module head_restore_step
    import head_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [HEAD_W-1:0]     data,
    input  logic [HEAD_REM_W-1:0] rem,
    output logic [HEAD_W-1:0]     data_next,
    output logic [HEAD_REM_W-1:0] rem_next,
    output logic                  last
);

    localparam int SH_W = 4;
    localparam logic [HEAD_REM_W-1:0] STEP_V = HEAD_REM_W'(STEP);

    logic [SH_W-1:0]   sh;
    logic [HEAD_W-1:0] stage [0:SH_W];

    // sh never exceeds STEP (at most 8), so four stages cover every amount.
    always_comb begin
        sh = (rem < STEP_V) ? rem[SH_W-1:0] : STEP_V[SH_W-1:0];
    end

    assign stage[0] = data;

    genvar gi;
    generate
        for (gi = 0; gi < SH_W; gi++) begin : g_stage
            assign stage[gi+1] = sh[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
        end
    endgenerate

    assign data_next = stage[SH_W];
    assign rem_next  = rem - {{(HEAD_REM_W-SH_W){1'b0}}, sh};
    assign last      = (rem_next == '0);

endmodule

// File: rtl/head_restore.sv
// Iterative denormalizer: data_out = norm_in >> pos_in, STEP bits per cycle.
// Optional malformed-input flag enabled by defining HEAD_RESTORE_CHECK_EN.
module head_restore
    import head_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HEAD_W-1:0]     norm_in,
    input  logic [HEAD_POS_W-1:0] pos_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [HEAD_W-1:0]     data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_out
);

    head_restore_state_t   state_reg, state_next;
    logic [HEAD_W-1:0]     shift_reg, shift_next;
    logic [HEAD_REM_W-1:0] rem_reg, rem_next;
    logic [HEAD_REM_W-1:0] pos_clamped;

    logic [HEAD_W-1:0]     step_data;
    logic [HEAD_REM_W-1:0] step_rem;
    logic                  step_last;

    head_restore_step #(
        .STEP (STEP)
    ) u_step (
        .data      (shift_reg),
        .rem       (rem_reg),
        .data_next (step_data),
        .rem_next  (step_rem),
        .last      (step_last)
    );

    assign pos_clamped = clamp_pos(pos_in);

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    shift_next = norm_in;
                    rem_next   = pos_clamped;
                    state_next = (pos_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift_next = step_data;
                rem_next   = step_rem;
                if (step_last)
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            rem_reg   <= rem_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign data_out  = shift_reg;

`ifdef HEAD_RESTORE_CHECK_EN
    logic err_reg, err_next;

    // Flag is latched at acceptance and only exposed while the result is presented.
    always_comb begin
        err_next = err_reg;
        if (state_reg == IDLE && in_valid)
            err_next = ((norm_in != '0) && !norm_in[HEAD_W-1])
                    || (pos_in > HEAD_POS_W'(HEAD_W-1))
                    || ((norm_in == '0) && (pos_in != '0));
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else
            err_reg <= err_next;
    end

    assign err_out = err_reg && (state_reg == DONE);
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_head_restore.sv
// Scoreboard bench for head_restore: STEP=4 and STEP=1 instances share stimulus,
// each with its own expectation queue and monitor.
module tb_head_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] norm_in;
    logic [5:0]  pos_in;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready4, out_valid4, err4;
    logic [31:0] data4;
    logic        in_ready1, out_valid1, err1;
    logic [31:0] data1;

    always #5 clk = ~clk;

    head_restore #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst), .norm_in(norm_in), .pos_in(pos_in),
        .in_valid(in_valid), .in_ready(in_ready4), .data_out(data4),
        .out_valid(out_valid4), .out_ready(out_ready), .err_out(err4)
    );

    head_restore #(.STEP(1)) dut1 (
        .clk(clk), .rst(rst), .norm_in(norm_in), .pos_in(pos_in),
        .in_valid(in_valid), .in_ready(in_ready1), .data_out(data1),
        .out_valid(out_valid1), .out_ready(out_ready), .err_out(err1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          vcyc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    typedef struct packed {
        logic [31:0] norm;
        logic [5:0]  pos;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    // norm_in, pos_in, expected data_out, expected flag when checking is enabled
    vec_t vecs [11] = '{
        '{32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0},
        '{32'hA000_0000, 6'd5,  32'h0500_0000, 1'b0},
        '{32'hC000_0000, 6'd0,  32'hC000_0000, 1'b0},
        '{32'h8000_0000, 6'd3,  32'h1000_0000, 1'b0},
        '{32'h0000_0000, 6'd0,  32'h0000_0000, 1'b0},
        '{32'h4000_0000, 6'd2,  32'h1000_0000, 1'b1},
        '{32'h8000_0000, 6'd40, 32'h0000_0000, 1'b1},
        '{32'h8000_0000, 6'd32, 32'h0000_0000, 1'b1},
        '{32'hFFFF_FFFF, 6'd4,  32'h0FFF_FFFF, 1'b0},
        '{32'h0000_0000, 6'd7,  32'h0000_0000, 1'b1},
        '{32'h9000_0000, 6'd63, 32'h0000_0000, 1'b1}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Per-cycle monitor body; pv/prdy/pd are the values seen one cycle earlier.
    task automatic mon(input string tag, input logic ov, input logic ir, input logic er,
                       input logic [31:0] d, input logic pv, input logic prdy,
                       input logic [31:0] pd, input bit have, input bit rise, input exp_t e);
        if (rise) begin
            if (!have) begin
                fail_now({tag, "_unexpected_out_valid"});
            end else begin
                check({tag, "_data"}, d, e.data);
                check({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
                check({tag, "_latency"}, 32'(cyc), 32'(e.vcyc));
                $display("%s token: data %h err %0b at cycle %0d", tag, d, er, cyc);
            end
        end
        if (pv && !prdy) begin
            check({tag, "_hold_valid"}, {31'b0, ov}, 32'd1);
            check({tag, "_hold_data"}, d, pd);
            check({tag, "_hold_in_ready"}, {31'b0, ir}, 32'd0);
        end
        if (pv && prdy) begin
            check({tag, "_release_valid"}, {31'b0, ov}, 32'd0);
            check({tag, "_release_in_ready"}, {31'b0, ir}, 32'd1);
        end
        if (ov !== 1'b1)
            check({tag, "_err_outside_done"}, {31'b0, er}, 32'd0);
    endtask

    initial begin : mon4
        logic pv, prdy;
        logic [31:0] pd;
        exp_t e;
        bit have, rise;
        pv = 1'b0; prdy = 1'b1; pd = '0;
        forever begin
            @(negedge clk);
            rise = (out_valid4 === 1'b1) && !pv;
            have = rise && (q4.size() > 0);
            e = '{32'h0, 1'b0, 0};
            if (have) e = q4.pop_front();
            if (rst !== 1'b1)
                mon("step4", out_valid4, in_ready4, err4, data4, pv, prdy, pd, have, rise, e);
            pv = (out_valid4 === 1'b1);
            prdy = out_ready;
            pd = data4;
        end
    end

    initial begin : mon1
        logic pv, prdy;
        logic [31:0] pd;
        exp_t e;
        bit have, rise;
        pv = 1'b0; prdy = 1'b1; pd = '0;
        forever begin
            @(negedge clk);
            rise = (out_valid1 === 1'b1) && !pv;
            have = rise && (q1.size() > 0);
            e = '{32'h0, 1'b0, 0};
            if (have) e = q1.pop_front();
            if (rst !== 1'b1)
                mon("step1", out_valid1, in_ready1, err1, data1, pv, prdy, pd, have, rise, e);
            pv = (out_valid1 === 1'b1);
            prdy = out_ready;
            pd = data1;
        end
    end

    task automatic send(input logic [31:0] nv, input logic [5:0] pv, input logic [31:0] ex,
                        input logic er, input bit push);
        int c;
        int w;
        logic er_exp;
        w = 0;
        @(posedge clk); #1;
        while (!(in_ready4 && in_ready1)) begin
            if (w++ > 200) begin
                fail_now("in_ready_timeout");
                return;
            end
            @(posedge clk); #1;
        end
`ifdef HEAD_RESTORE_CHECK_EN
        er_exp = er;
`else
        er_exp = 1'b0;
`endif
        norm_in  = nv;
        pos_in   = pv;
        in_valid = 1'b1;
        c = (pv > 6'd32) ? 32 : int'(pv);
        if (push) begin
            q4.push_back('{ex, er_exp, cyc + 1 + (c + 3) / 4});
            q1.push_back('{ex, er_exp, cyc + 1 + c});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        norm_in  = $urandom;
        pos_in   = 6'($urandom);
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; norm_in = '0; pos_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_in_ready4", {31'b0, in_ready4}, 32'd1);
        check("reset_out_valid4", {31'b0, out_valid4}, 32'd0);
        check("reset_data4", data4, 32'h0);
        check("reset_err4", {31'b0, err4}, 32'd0);
        check("reset_in_ready1", {31'b0, in_ready1}, 32'd1);
        check("reset_data1", data1, 32'h0);

        foreach (vecs[i])
            send(vecs[i].norm, vecs[i].pos, vecs[i].exp, vecs[i].err, 1'b1);

        // Backpressure: hold both instances in DONE, pulse a token that must be ignored.
        @(posedge clk); #1;
        w = 0;
        while (!(in_ready4 && in_ready1) && w < 200) begin
            w++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        send(32'h8000_0000, 6'd6, 32'h0200_0000, 1'b0, 1'b1);
        w = 0;
        while (!(out_valid4 && out_valid1)) begin
            if (w++ > 200) begin
                fail_now("backpressure_valid_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b1; norm_in = 32'hFFFF_FFFF; pos_in = 6'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b1;

        // Reset in the middle of a shift discards the token.
        send(32'h8000_0000, 6'd20, 32'h0000_0800, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready4", {31'b0, in_ready4}, 32'd1);
        check("midreset_out_valid4", {31'b0, out_valid4}, 32'd0);
        check("midreset_data4", data4, 32'h0);
        check("midreset_in_ready1", {31'b0, in_ready1}, 32'd1);
        check("midreset_out_valid1", {31'b0, out_valid1}, 32'd0);
        check("midreset_data1", data1, 32'h0);
        send(32'h8000_0000, 6'd1, 32'h4000_0000, 1'b0, 1'b1);

        w = 0;
        while (q4.size() > 0 || q1.size() > 0) begin
            if (w++ > 500) begin
                fail_now("drain_timeout");
                break;
            end
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
